// File: rtl/pipeline_exe_muldiv_pkg.sv
// Shared operation codes, memory access types and helpers for the execute stage.
package pipeline_exe_muldiv_pkg;

   localparam int unsigned ALU_OP_W = 5;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_AND    = 5'd2,
      ALU_OR     = 5'd3,
      ALU_XOR    = 5'd4,
      ALU_SLL    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_SLT    = 5'd8,
      ALU_SLTU   = 5'd9,
      ALU_PASS_B = 5'd10,
      ALU_MUL    = 5'd16,
      ALU_MULH   = 5'd17,
      ALU_MULHSU = 5'd18,
      ALU_MULHU  = 5'd19,
      ALU_DIV    = 5'd20,
      ALU_DIVU   = 5'd21,
      ALU_REM    = 5'd22,
      ALU_REMU   = 5'd23
   } alu_op_e;

   // Low three bits of a MULDIV code, as seen by the iterative unit.
   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;

   localparam logic [3:0] DMEM_NO  = 4'd0;
   localparam logic [3:0] DMEM_LB  = 4'd1;
   localparam logic [3:0] DMEM_LH  = 4'd2;
   localparam logic [3:0] DMEM_LW  = 4'd3;
   localparam logic [3:0] DMEM_LBU = 4'd4;
   localparam logic [3:0] DMEM_LHU = 4'd5;
   localparam logic [3:0] DMEM_SB  = 4'd6;
   localparam logic [3:0] DMEM_SH  = 4'd7;
   localparam logic [3:0] DMEM_SW  = 4'd8;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

   function automatic logic is_muldiv(logic [ALU_OP_W-1:0] op);
      return op[4:3] == 2'b10;
   endfunction

   function automatic logic md_signed_a(logic [2:0] op);
      return op[2] ? ~op[0] : (op == MD_MULH || op == MD_MULHSU);
   endfunction

   function automatic logic md_signed_b(logic [2:0] op);
      return op[2] ? ~op[0] : (op == MD_MULH);
   endfunction

endpackage

// File: rtl/pipeline_exe_muldiv_muldiv_iter.sv
// Iterative RV32M unit: 32-step shift-add multiply / restoring divide on magnitudes,
// with the sign applied to the final word.
module muldiv_iter
   import pipeline_exe_muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   md_state_e   state_q;
   logic [4:0]  count_q;
   logic [63:0] acc_q;
   logic [31:0] mcand_q, a_q, b_q;
   logic [2:0]  op_q;

   logic [31:0] a_abs, b_abs;
   logic [32:0] add_sum, sub_diff;
   logic [63:0] acc_step, prod;
   logic [31:0] quo, rem;
   logic        neg_a, neg_b;

   always_comb begin
      a_abs = (md_signed_a(op) && a[31]) ? -a : a;
      b_abs = (md_signed_b(op) && b[31]) ? -b : b;
   end

   // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
   // Divide: {remainder, quotient} shifts left, subtracting the divisor when it fits.
   always_comb begin
      add_sum  = {1'b0, acc_q[63:32]} + {1'b0, mcand_q};
      sub_diff = acc_q[63:31] - {1'b0, mcand_q};
      if (op_q[2]) begin
         acc_step = sub_diff[32] ? {acc_q[62:0], 1'b0} : {sub_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
         acc_step = acc_q[0] ? {add_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         count_q <= 5'd0;
         acc_q   <= 64'd0;
         mcand_q <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         op_q    <= 3'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StBusy;
                  count_q <= 5'd0;
                  acc_q   <= op[2] ? {32'd0, a_abs} : {32'd0, b_abs};
                  mcand_q <= op[2] ? b_abs : a_abs;
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= op;
               end
            end
            StBusy: begin
               acc_q   <= acc_step;
               count_q <= count_q + 5'd1;
               if (count_q == 5'd31) state_q <= StDone;
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      neg_a = md_signed_a(op_q) & a_q[31];
      neg_b = md_signed_b(op_q) & b_q[31];
      prod  = (neg_a ^ neg_b) ? -acc_q : acc_q;
      quo   = (neg_a ^ neg_b) ? -acc_q[31:0] : acc_q[31:0];
      rem   = neg_a ? -acc_q[63:32] : acc_q[63:32];
      if (!op_q[2]) begin
         result = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
      end else if (b_q == 32'd0) begin
         // Divide by zero ignores operand signs entirely.
         result = op_q[1] ? a_q : 32'hFFFF_FFFF;
      end else begin
         result = op_q[1] ? rem : quo;
      end
   end

   assign busy = (state_q == StBusy);
   assign done = (state_q == StDone);

endmodule

// File: rtl/pipeline_exe_muldiv.sv
// Execute stage: single-cycle ALU plus iterative MULDIV that stalls decode and
// sends bubbles to MEM until its result is ready.
module pipeline_exe_muldiv
   import pipeline_exe_muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                valid_d_i,
   input  logic [ALU_OP_W-1:0] alu_op_d_i,
   input  logic [XLEN-1:0]     src_a_d_i,
   input  logic [XLEN-1:0]     src_b_d_i,
   input  logic [XLEN-1:0]     store_data_d_i,
   input  logic [3:0]          dmem_type_d_i,
   input  logic [XLEN-1:0]     extended_imm_d_i,
   input  logic [XLEN-1:0]     pc_plus_d_i,
   input  logic                reg_write_en_d_i,
   input  logic [4:0]          rd_idx_d_i,
   input  logic [3:0]          result_src_d_i,
   output logic                stall_e_o,
   output logic [XLEN-1:0]     alu_result_e_o,
   output logic [XLEN-1:0]     rs1_e_o,
   output logic [XLEN-1:0]     extended_imm_e_o,
   output logic [XLEN-1:0]     pc_plus_e_o,
   output logic [3:0]          dmem_type_e_o,
   output logic                reg_write_en_e_o,
   output logic [4:0]          rd_idx_e_o,
   output logic [3:0]          result_src_e_o
);

   logic            md_start, md_busy, md_done;
   logic [31:0]     md_result;
   logic [XLEN-1:0] alu_result;
   logic [4:0]      shamt;

   assign md_start  = valid_d_i & is_muldiv(alu_op_d_i) & ~md_busy & ~md_done;
   assign stall_e_o = md_start | md_busy;
   assign shamt     = src_b_d_i[4:0];

   muldiv_iter u_muldiv_iter (
      .clk    (clk),
      .resetn (resetn),
      .start  (md_start),
      .op     (alu_op_d_i[2:0]),
      .a      (src_a_d_i),
      .b      (src_b_d_i),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   always_comb begin
      case (alu_op_d_i)
         ALU_SUB:    alu_result = src_a_d_i - src_b_d_i;
         ALU_AND:    alu_result = src_a_d_i & src_b_d_i;
         ALU_OR:     alu_result = src_a_d_i | src_b_d_i;
         ALU_XOR:    alu_result = src_a_d_i ^ src_b_d_i;
         ALU_SLL:    alu_result = src_a_d_i << shamt;
         ALU_SRL:    alu_result = src_a_d_i >> shamt;
         ALU_SRA:    alu_result = $unsigned($signed(src_a_d_i) >>> shamt);
         ALU_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(src_a_d_i) < $signed(src_b_d_i)};
         ALU_SLTU:   alu_result = {{(XLEN-1){1'b0}}, src_a_d_i < src_b_d_i};
         ALU_PASS_B: alu_result = src_b_d_i;
         default:    alu_result = src_a_d_i + src_b_d_i;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         alu_result_e_o   <= '0;
         rs1_e_o          <= '0;
         extended_imm_e_o <= '0;
         pc_plus_e_o      <= '0;
         dmem_type_e_o    <= DMEM_NO;
         reg_write_en_e_o <= 1'b0;
         rd_idx_e_o       <= 5'd0;
         result_src_e_o   <= 4'd0;
      end else if (stall_e_o || !(valid_d_i || md_done)) begin
         // Bubble: nothing reaches MEM, so a held store can never be issued twice.
         alu_result_e_o   <= '0;
         rs1_e_o          <= '0;
         extended_imm_e_o <= '0;
         pc_plus_e_o      <= '0;
         dmem_type_e_o    <= DMEM_NO;
         reg_write_en_e_o <= 1'b0;
         rd_idx_e_o       <= 5'd0;
         result_src_e_o   <= 4'd0;
      end else begin
         alu_result_e_o   <= md_done ? md_result : alu_result;
         rs1_e_o          <= store_data_d_i;
         extended_imm_e_o <= extended_imm_d_i;
         pc_plus_e_o      <= pc_plus_d_i;
         dmem_type_e_o    <= dmem_type_d_i;
         reg_write_en_e_o <= reg_write_en_d_i;
         rd_idx_e_o       <= rd_idx_d_i;
         result_src_e_o   <= result_src_d_i;
      end
   end

endmodule

// File: tb/tb_pipeline_exe_muldiv.sv
// Randomized and directed bench for the execute stage against an arithmetic reference model.
module tb_pipeline_exe_muldiv;
   import pipeline_exe_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        valid_d_i;
   logic [4:0]  alu_op_d_i;
   logic [31:0] src_a_d_i, src_b_d_i, store_data_d_i, extended_imm_d_i, pc_plus_d_i;
   logic [3:0]  dmem_type_d_i, result_src_d_i;
   logic        reg_write_en_d_i;
   logic [4:0]  rd_idx_d_i;
   logic        stall_e_o;
   logic [31:0] alu_result_e_o, rs1_e_o, extended_imm_e_o, pc_plus_e_o;
   logic [3:0]  dmem_type_e_o, result_src_e_o;
   logic        reg_write_en_e_o;
   logic [4:0]  rd_idx_e_o;

   int tests = 0;
   int fails = 0;
   int sw_seen = 0;

   always #5 clk = ~clk;

   pipeline_exe_muldiv #(.XLEN(32)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .valid_d_i        (valid_d_i),
      .alu_op_d_i       (alu_op_d_i),
      .src_a_d_i        (src_a_d_i),
      .src_b_d_i        (src_b_d_i),
      .store_data_d_i   (store_data_d_i),
      .dmem_type_d_i    (dmem_type_d_i),
      .extended_imm_d_i (extended_imm_d_i),
      .pc_plus_d_i      (pc_plus_d_i),
      .reg_write_en_d_i (reg_write_en_d_i),
      .rd_idx_d_i       (rd_idx_d_i),
      .result_src_d_i   (result_src_d_i),
      .stall_e_o        (stall_e_o),
      .alu_result_e_o   (alu_result_e_o),
      .rs1_e_o          (rs1_e_o),
      .extended_imm_e_o (extended_imm_e_o),
      .pc_plus_e_o      (pc_plus_e_o),
      .dmem_type_e_o    (dmem_type_e_o),
      .reg_write_en_e_o (reg_write_en_e_o),
      .rd_idx_e_o       (rd_idx_e_o),
      .result_src_e_o   (result_src_e_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(logic [4:0] op, logic [31:0] a, logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = a;
      ib = b;
      case (op)
         ALU_SUB:    return a - b;
         ALU_AND:    return a & b;
         ALU_OR:     return a | b;
         ALU_XOR:    return a ^ b;
         ALU_SLL:    return a << b[4:0];
         ALU_SRL:    return a >> b[4:0];
         ALU_SRA:    return $unsigned($signed(a) >>> b[4:0]);
         ALU_SLT:    return (ia < ib) ? 32'd1 : 32'd0;
         ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
         ALU_PASS_B: return b;
         ALU_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
         ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
         ALU_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
         ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
         ALU_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         ALU_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(ia % ib);
         end
         ALU_REMU: return (b == 0) ? a : a % b;
         default:  return a + b;
      endcase
   endfunction

   // Decode must hold its inputs steady in the cycle after any stalled cycle.
   logic [201:0] bundle, held;
   logic         hold_armed;
   assign bundle = {valid_d_i, alu_op_d_i, src_a_d_i, src_b_d_i, store_data_d_i, dmem_type_d_i,
                    extended_imm_d_i, pc_plus_d_i, reg_write_en_d_i, rd_idx_d_i, result_src_d_i};

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_armed <= 1'b0;
      end else begin
         if (hold_armed) check("decode_hold", 64'(bundle == held), 64'd1);
         hold_armed <= stall_e_o;
         held       <= bundle;
      end
   end

   always @(negedge clk) if (dmem_type_e_o == DMEM_SW) sw_seen <= sw_seen + 1;

   task automatic check_bubble(input string tag);
      check({tag, "_we"}, reg_write_en_e_o, 0);
      check({tag, "_dmem"}, dmem_type_e_o, DMEM_NO);
      check({tag, "_res"}, alu_result_e_o, 0);
   endtask

   // Called just after a rising edge; returns just after the edge that shows the result.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] dm, input logic rw, input logic [4:0] rd);
      logic [31:0] sd, imm, pc;
      logic [3:0]  rs;
      logic        md;
      int          n;
      sd  = $urandom;
      imm = $urandom;
      pc  = $urandom;
      rs  = 4'($urandom_range(0, 15));
      md  = (op >= ALU_MUL && op <= ALU_REMU);
      valid_d_i        = 1'b1;
      alu_op_d_i       = op;
      src_a_d_i        = a;
      src_b_d_i        = b;
      store_data_d_i   = sd;
      dmem_type_d_i    = dm;
      extended_imm_d_i = imm;
      pc_plus_d_i      = pc;
      reg_write_en_d_i = rw;
      rd_idx_d_i       = rd;
      result_src_d_i   = rs;
      #1;
      check("stall_issue", stall_e_o, md);
      n = stall_e_o ? 1 : 0;
      while (stall_e_o && n < 40) begin
         @(posedge clk);
         #2;
         if (stall_e_o) n++;
         check_bubble("bubble");
      end
      if (md) check("stall_len", n, 33);
      @(posedge clk);
      #1;
      check("result", alu_result_e_o, ref_op(op, a, b));
      check("rs1", rs1_e_o, sd);
      check("imm", extended_imm_e_o, imm);
      check("pc_plus", pc_plus_e_o, pc);
      check("dmem", dmem_type_e_o, dm);
      check("we", reg_write_en_e_o, rw);
      check("rd", rd_idx_e_o, rd);
      check("rsrc", result_src_e_o, rs);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   logic [4:0] op_pool [21];
   int         sw_before;

   initial begin
      op_pool = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
                  ALU_SLT, ALU_SLTU, ALU_PASS_B, 5'd12, 5'd31, ALU_MUL, ALU_MULH, ALU_MULHSU,
                  ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      resetn = 1'b0;
      valid_d_i = 1'b0;
      alu_op_d_i = 5'd0;
      src_a_d_i = 0; src_b_d_i = 0; store_data_d_i = 0; extended_imm_d_i = 0; pc_plus_d_i = 0;
      dmem_type_d_i = DMEM_NO; reg_write_en_d_i = 1'b0; rd_idx_d_i = 5'd0; result_src_d_i = 4'd0;
      #12;
      check("rst_stall", stall_e_o, 0);
      check_bubble("rst");
      check("rst_rd", rd_idx_e_o, 0);
      check("rst_rsrc", result_src_e_o, 0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      run_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1, DMEM_NO, 1'b1, 5'd5);
      check("add_stall", stall_e_o, 0);
      run_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, DMEM_NO, 1'b1, 5'd3);
      run_op(ALU_MULHU, 32'd7, 32'hFFFF_FFFD, DMEM_NO, 1'b1, 5'd4);
      run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DMEM_NO, 1'b1, 5'd6);
      run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, DMEM_NO, 1'b1, 5'd7);
      run_op(ALU_DIVU, 32'd5, 32'd0, DMEM_NO, 1'b1, 5'd8);
      run_op(ALU_REMU, 32'd5, 32'd0, DMEM_NO, 1'b1, 5'd9);
      run_op(ALU_DIVU, 32'd100, 32'd7, DMEM_NO, 1'b1, 5'd10);
      run_op(ALU_REMU, 32'd100, 32'd7, DMEM_NO, 1'b1, 5'd11);

      // A store right behind a multiply reaches MEM exactly once.
      sw_before = sw_seen;
      run_op(ALU_MUL, 32'd3, 32'd9, DMEM_NO, 1'b1, 5'd12);
      run_op(ALU_ADD, 32'h1000, 32'd8, DMEM_SW, 1'b0, 5'd0);
      valid_d_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("sw_count", sw_seen - sw_before, 1);

      // Reset in the middle of a divide.
      valid_d_i  = 1'b1;
      alu_op_d_i = ALU_DIV;
      src_a_d_i  = 32'd1000;
      src_b_d_i  = 32'd3;
      repeat (10) @(posedge clk);
      #3;
      valid_d_i = 1'b0;
      resetn    = 1'b0;
      #1;
      check("midrst_stall", stall_e_o, 0);
      check_bubble("midrst");
      @(posedge clk);
      #3;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      run_op(ALU_ADD, 32'd2, 32'd3, DMEM_NO, 1'b1, 5'd1);

      for (int i = 0; i < 30; i++) begin
         run_op(op_pool[$urandom_range(0, 20)], pick_operand(), pick_operand(),
                4'($urandom_range(0, 8)), 1'($urandom), 5'($urandom));
      end
      valid_d_i = 1'b0;
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
